// File: rtl/ram_read_check.sv
// Read-side checker for the test RAM fill: sweeps every address once and compares returned data with the fill pattern.
// Optional first-mismatch capture is enabled by defining RAM_CHK_FIRST_ERR_EN.
module ram_read_check #(
   parameter int unsigned AW       = 5,
   parameter int unsigned DW       = 8,
   parameter int unsigned READ_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          enb,
   output logic [AW-1:0] addrb,
   input  logic [DW-1:0] doutb,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW:0]   err_cnt,
   output logic [AW-1:0] first_err_addr,
   output logic [DW-1:0] first_err_data
);

   localparam int unsigned   DEPTH      = 2 ** AW;
   localparam logic [DW-1:0] DEPTH_DATA = DW'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic          enb_q, enb_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   err_cnt_q, err_cnt_d;
   logic          pass_q, pass_d;

   logic [READ_LAT:1] pipe_v_q, pipe_v_d;
   logic [AW-1:0]     pipe_a_q [READ_LAT:1];
   logic [AW-1:0]     pipe_a_d [READ_LAT:1];

   logic [AW-1:0] cmp_addr;
   logic [DW-1:0] exp_data;
   logic          mismatch;
   logic          drain_pending;
   logic          accept;

   always_comb begin
      cmp_addr = pipe_a_q[READ_LAT];
      exp_data = (cmp_addr == '0) ? DEPTH_DATA : DW'(cmp_addr);
      mismatch = pipe_v_q[READ_LAT] && (doutb != exp_data);
      accept   = (state_q == S_IDLE) && start;
   end

   // Entries in the last stage are consumed this edge, so only earlier stages keep DRAIN alive.
   always_comb begin
      drain_pending = 1'b0;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
         drain_pending = drain_pending | pipe_v_q[i];
      end
   end

   always_comb begin
      pipe_v_d    = pipe_v_q;
      pipe_a_d    = pipe_a_q;
      pipe_v_d[1] = enb_q;
      pipe_a_d[1] = addr_q;
      for (int unsigned i = 2; i <= READ_LAT; i++) begin
         pipe_v_d[i] = pipe_v_q[i-1];
         pipe_a_d[i] = pipe_a_q[i-1];
      end
   end

   always_comb begin
      state_d   = state_q;
      enb_d     = enb_q;
      addr_d    = addr_q;
      err_cnt_d = err_cnt_q;
      pass_d    = pass_q;

      if (mismatch) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_READ;
               enb_d     = 1'b1;
               addr_d    = '0;
               err_cnt_d = '0;
               pass_d    = 1'b0;
            end
         end
         S_READ: begin
            addr_d = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
               state_d = S_DRAIN;
               enb_d   = 1'b0;
               addr_d  = '0;
            end
         end
         S_DRAIN: begin
            if (!drain_pending) begin
               state_d = S_DONE;
               pass_d  = (err_cnt_d == '0);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         enb_q     <= 1'b0;
         addr_q    <= '0;
         err_cnt_q <= '0;
         pass_q    <= 1'b0;
         pipe_v_q  <= '0;
         pipe_a_q  <= '{default: '0};
      end else begin
         state_q   <= state_d;
         enb_q     <= enb_d;
         addr_q    <= addr_d;
         err_cnt_q <= err_cnt_d;
         pass_q    <= pass_d;
         pipe_v_q  <= pipe_v_d;
         pipe_a_q  <= pipe_a_d;
      end
   end

`ifdef RAM_CHK_FIRST_ERR_EN
   logic [AW-1:0] first_addr_q, first_addr_d;
   logic [DW-1:0] first_data_q, first_data_d;

   // A zero error count before this compare marks the first mismatch of the sweep.
   always_comb begin
      first_addr_d = first_addr_q;
      first_data_d = first_data_q;
      if (accept) begin
         first_addr_d = '0;
         first_data_d = '0;
      end else if (mismatch && (err_cnt_q == '0)) begin
         first_addr_d = cmp_addr;
         first_data_d = doutb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         first_addr_q <= '0;
         first_data_q <= '0;
      end else begin
         first_addr_q <= first_addr_d;
         first_data_q <= first_data_d;
      end
   end

   assign first_err_addr = first_addr_q;
   assign first_err_data = first_data_q;
`else
   logic unused_accept;
   assign unused_accept  = accept;
   assign first_err_addr = '0;
   assign first_err_data = '0;
`endif

   assign enb     = enb_q;
   assign addrb   = addr_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign pass    = pass_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ram_read_check.sv
// Directed bench for ram_read_check: two checkers (READ_LAT 1 and 2) each reading a behavioural RAM model.
module tb_ram_read_check;

   logic       clk;
   logic       rst;
   logic       start1, start2;
   logic       enb1, enb2;
   logic [4:0] addr1, addr2;
   logic [7:0] dout1, dout2;
   logic       busy1, busy2, done1, done2, pass1, pass2;
   logic [5:0] err1, err2;
   logic [4:0] fea1, fea2;
   logic [7:0] fed1, fed2;

   logic [7:0] mem1 [32];
   logic [7:0] mem2 [32];
   logic [7:0] r1_s1, r2_s1, r2_s2;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;

`ifdef RAM_CHK_FIRST_ERR_EN
   localparam bit FE = 1'b1;
`else
   localparam bit FE = 1'b0;
`endif

   ram_read_check #(.AW(5), .DW(8), .READ_LAT(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .enb(enb1), .addrb(addr1), .doutb(dout1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .first_err_addr(fea1), .first_err_data(fed1)
   );

   ram_read_check #(.AW(5), .DW(8), .READ_LAT(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .enb(enb2), .addrb(addr2), .doutb(dout2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
      .first_err_addr(fea2), .first_err_data(fed2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      r1_s1 <= mem1[addr1];
      r2_s1 <= mem2[addr2];
      r2_s2 <= r2_s1;
   end
   assign dout1 = r1_s1;
   assign dout2 = r2_s2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill();
      for (int a = 0; a < 32; a++) begin
         mem1[a] = (a == 0) ? 8'd32 : 8'(a);
         mem2[a] = (a == 0) ? 8'd32 : 8'(a);
      end
   endtask

   // Pulses start on the selected checker; cyc is the cycle number where done was seen.
   task automatic sweep(input int sel, output int cyc);
      if (sel == 1) start1 = 1'b1;
      else          start2 = 1'b1;
      tick();
      start1 = 1'b0;
      start2 = 1'b0;
      cyc = 1;
      while (!((sel == 1) ? done1 : done2) && cyc < 100) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int c, dcyc, ndone;
      rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
      fill();
      tick(); tick();
      chk("rst_enb",   32'(enb1),  0);
      chk("rst_addr",  32'(addr1), 0);
      chk("rst_busy",  32'(busy1), 0);
      chk("rst_done",  32'(done1), 0);
      chk("rst_pass",  32'(pass1), 0);
      chk("rst_err",   32'(err1),  0);
      chk("rst_fea",   32'(fea1),  0);
      chk("rst_fed",   32'(fed1),  0);
      chk("rst_busy2", 32'(busy2), 0);
      rst = 1'b0;
      tick();

      // Test 1: clean fill, address sequence and done timing
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         chk($sformatf("t1_enb_c%0d", k),  32'(enb1),  1);
         chk($sformatf("t1_addr_c%0d", k), 32'(addr1), 32'(k - 1));
         tick();
      end
      chk("t1_enb_c33",  32'(enb1),  0);
      chk("t1_addr_c33", 32'(addr1), 0);
      chk("t1_busy_c33", 32'(busy1), 1);
      chk("t1_done_c33", 32'(done1), 0);
      tick();
      chk("t1_done_c34", 32'(done1), 1);
      chk("t1_busy_c34", 32'(busy1), 1);
      chk("t1_pass",     32'(pass1), 1);
      chk("t1_err",      32'(err1),  0);
      tick();
      chk("t1_done_c35", 32'(done1), 0);
      chk("t1_busy_c35", 32'(busy1), 0);
      chk("t1_pass_hold", 32'(pass1), 1);

      // Test 2: single corrupted word
      mem1[5] = 8'hAA;
      sweep(1, c);
      chk("t2_done_cyc", 32'(c), 34);
      chk("t2_err",  32'(err1), 1);
      chk("t2_pass", 32'(pass1), 0);
      chk("t2_fea",  32'(fea1), FE ? 32'd5 : 32'd0);
      chk("t2_fed",  32'(fed1), FE ? 32'hAA : 32'd0);
      tick(); tick();
      chk("t2_err_hold", 32'(err1), 1);
      chk("t2_fea_hold", 32'(fea1), FE ? 32'd5 : 32'd0);
      mem1[5] = 8'd5;

      // Test 3: READ_LAT=2, first and last words wrong
      mem2[0]  = 8'h00;
      mem2[31] = 8'h00;
      sweep(2, c);
      chk("t3_done_cyc", 32'(c), 35);
      chk("t3_err",  32'(err2), 2);
      chk("t3_pass", 32'(pass2), 0);
      chk("t3_fea",  32'(fea2), 0);
      chk("t3_fed",  32'(fed2), 0);
      tick();
      chk("t3_idle", 32'(busy2), 0);

      // Test 4: start clears counters; start while busy is ignored
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("t4_err_clr",  32'(err1),  0);
      chk("t4_fea_clr",  32'(fea1),  0);
      chk("t4_fed_clr",  32'(fed1),  0);
      chk("t4_busy",     32'(busy1), 1);
      c = 1; dcyc = 0; ndone = 0;
      repeat (45) begin
         if (done1) begin
            ndone++;
            if (dcyc == 0) dcyc = c;
         end
         start1 = (c == 10);
         tick();
         c++;
      end
      start1 = 1'b0;
      chk("t4_ndone",    32'(ndone), 1);
      chk("t4_done_cyc", 32'(dcyc),  34);
      chk("t4_pass",     32'(pass1), 1);
      chk("t4_err",      32'(err1),  0);
      chk("t4_idle",     32'(busy1), 0);
      mem1[3] = 8'hAA;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("t4_pass_clr", 32'(pass1), 0);

      // Test 5: reset mid-sweep
      repeat (11) tick();
      chk("t5_err_pre", 32'(err1), 1);
      chk("t5_enb_pre", 32'(enb1), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem1[3] = 8'd3;
      chk("t5_enb",  32'(enb1),  0);
      chk("t5_busy", 32'(busy1), 0);
      chk("t5_err",  32'(err1),  0);
      chk("t5_addr", 32'(addr1), 0);
      chk("t5_fea",  32'(fea1),  0);
      ndone = 0;
      repeat (40) begin
         if (done1) ndone++;
         tick();
      end
      chk("t5_no_done", 32'(ndone), 0);
      sweep(1, c);
      chk("t5_done_cyc", 32'(c), 34);
      chk("t5_pass", 32'(pass1), 1);
      chk("t5_errf", 32'(err1),  0);
      tick();

      // start coincident with reset is lost
      rst = 1'b1; start1 = 1'b1;
      tick();
      rst = 1'b0; start1 = 1'b0;
      chk("rs_busy",  32'(busy1), 0);
      chk("rs_pass",  32'(pass1), 0);
      tick();
      chk("rs_busy2", 32'(busy1), 0);
      chk("rs_enb",   32'(enb1),  0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
